// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - next fetch address select: hold, sequential pc+4, or aligned redirect target
module if_next_pc
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  // 32-bit add wraps naturally, so 0xFFFF_FFFC advances to 0.
  assign pc_plus4_o = pc_i + 32'd4;

  always_comb begin
    next_pc_o = pc_i;
    if (redirect_i) begin
      next_pc_o = align_word(redirect_pc_i);
    end else if (advance_i) begin
      next_pc_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - single-outstanding instruction fetch FSM with IF/ID holding register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         valid_q, valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0]  instr_q, instr_d;
  logic         advance;
  logic [31:0]  pc_plus4;

  if_next_pc u_next_pc (
    .pc_i          (pc_q),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance),
    .pc_plus4_o    (pc_plus4),
    .next_pc_o     (pc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= align_word(RESET_PC);
      discard_q     <= 1'b0;
      valid_q       <= 1'b0;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      instr_q       <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      valid_q       <= valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      instr_q       <= instr_d;
    end
  end

  // Redirect is honoured in every state; pc_d already folds it in via if_next_pc.
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    valid_d       = valid_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    instr_d       = instr_q;
    advance       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          state_d   = ST_WAIT;
          discard_d = redirect;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (redirect || discard_q) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
          end else begin
            state_d       = ST_HOLD;
            valid_d       = 1'b1;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            instr_d       = imem_rdata;
            advance       = 1'b1;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect || !stall) begin
          state_d = ST_REQ;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ);
    imem_addr = align_word(pc_q);
  end

  assign if_valid       = valid_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_plus4_q;
  assign if_instruction = instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_pc_plus4, if_instruction;

  logic        rst_b, stall_b, redirect_b, gnt_b, rvalid_b;
  logic [31:0] redirect_pc_b, rdata_b;
  logic        req_b, valid_b;
  logic [31:0] addr_b, pc_b, pc_plus4_b, instr_b;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$];
  fetch_t      exp_fetch_q[$];

  if_fetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instruction (if_instruction)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk            (clk),
    .rst            (rst_b),
    .stall          (stall_b),
    .redirect       (redirect_b),
    .redirect_pc    (redirect_pc_b),
    .imem_req       (req_b),
    .imem_addr      (addr_b),
    .imem_gnt       (gnt_b),
    .imem_rvalid    (rvalid_b),
    .imem_rdata     (rdata_b),
    .if_valid       (valid_b),
    .if_pc          (pc_b),
    .if_pc_plus4    (pc_plus4_b),
    .if_instruction (instr_b)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    for (int i = 0; i < 16 && !imem_req; i++) step();
    if (!imem_req) fail_now("req_timeout");
    check32("req_addr_direct", imem_addr, addr);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    fetch_t f;
    wait_req(addr);
    f.pc = addr;
    f.instr = data;
    exp_addr_q.push_back(addr);
    exp_fetch_q.push_back(f);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Monitor: pops expectations on each granted request and on each new held instruction.
  initial begin
    logic   prev_valid;
    fetch_t f;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (imem_req && imem_gnt) begin
          if (exp_addr_q.size() == 0) fail_now("unexpected_request");
          else check32("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (if_valid && !prev_valid) begin
          if (exp_fetch_q.size() == 0) begin
            fail_now("unexpected_valid");
          end else begin
            f = exp_fetch_q.pop_front();
            check32("if_pc", if_pc, f.pc);
            check32("if_pc_plus4", if_pc_plus4, f.pc + 32'd4);
            check32("if_instruction", if_instruction, f.instr);
          end
        end
        prev_valid = if_valid;
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    rst_b = 1'b1; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'h0;
    gnt_b = 1'b0; rvalid_b = 1'b0; rdata_b = 32'h0;

    repeat (2) step();
    check1("rst_imem_req", imem_req, 1'b0);
    check32("rst_imem_addr", imem_addr, 32'h0);
    check1("rst_if_valid", if_valid, 1'b0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    check32("rst_if_instruction", if_instruction, NOP_INSTR);
    rst = 1'b0;
    step();

    // First fetch with stall already high, then held for three cycles.
    stall = 1'b1;
    fetch(32'h0, 32'h0050_0093);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("hold_valid", if_valid, 1'b1);
      check32("hold_instr", if_instruction, 32'h0050_0093);
      check32("hold_pc", if_pc, 32'h0);
      check1("hold_no_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    step();
    check1("consume_valid", if_valid, 1'b0);
    check32("consume_nop", if_instruction, NOP_INSTR);
    fetch(32'h4, 32'h00a0_0113);

    // Redirect while waiting for data; the in-flight response must be dropped.
    wait_req(32'h8);
    exp_addr_q.push_back(32'h8);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check1("wait_redir_dropped", if_valid, 1'b0);
    check1("wait_redir_req", imem_req, 1'b1);
    check32("wait_redir_addr", imem_addr, 32'h0000_0100);
    stall = 1'b1;
    fetch(32'h100, 32'h0010_8093);

    // Redirect together with stall in HOLD: redirect wins.
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    check1("hold_redir_valid", if_valid, 1'b0);
    check32("hold_redir_nop", if_instruction, NOP_INSTR);
    check1("hold_redir_req", imem_req, 1'b1);
    check32("hold_redir_addr", imem_addr, 32'h0000_0200);
    stall = 1'b0;
    fetch(32'h200, 32'h0021_0113);

    // Redirect in the same cycle as the grant.
    wait_req(32'h204);
    exp_addr_q.push_back(32'h204);
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    imem_gnt = 1'b0; redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    step();
    imem_rvalid = 1'b0;
    check1("gnt_redir_dropped", if_valid, 1'b0);
    check32("gnt_redir_addr", imem_addr, 32'h0000_0300);
    fetch(32'h300, 32'h0031_8193);

    // Redirect in the same cycle as rvalid; low address bits are ignored.
    wait_req(32'h304);
    exp_addr_q.push_back(32'h304);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    redirect = 1'b1; redirect_pc = 32'h0000_0403;
    step();
    imem_rvalid = 1'b0; redirect = 1'b0;
    check1("rv_redir_dropped", if_valid, 1'b0);
    check1("rv_redir_req", imem_req, 1'b1);
    check32("rv_redir_addr", imem_addr, 32'h0000_0400);
    fetch(32'h400, 32'h0042_0213);

    // Reset while waiting; a late response after release is ignored.
    wait_req(32'h404);
    exp_addr_q.push_back(32'h404);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check1("midrst_req", imem_req, 1'b0);
    check32("midrst_addr", imem_addr, 32'h0);
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    step();
    imem_rvalid = 1'b0;
    check1("late_rvalid_ignored", if_valid, 1'b0);
    fetch(32'h0, 32'h0052_8293);
    repeat (3) step();
    check_int("addr_queue_drained", exp_addr_q.size(), 0);
    check_int("fetch_queue_drained", exp_fetch_q.size(), 0);

    // Wrap-around instance: RESET_PC at the top of the address space.
    check32("wrap_rst_addr", addr_b, 32'hFFFF_FFFC);
    rst_b = 1'b0;
    step();
    check1("wrap_req", req_b, 1'b1);
    gnt_b = 1'b1;
    step();
    gnt_b = 1'b0;
    rvalid_b = 1'b1; rdata_b = 32'h0010_0073;
    step();
    rvalid_b = 1'b0;
    check1("wrap_valid", valid_b, 1'b1);
    check32("wrap_if_pc", pc_b, 32'hFFFF_FFFC);
    check32("wrap_if_pc_plus4", pc_plus4_b, 32'h0);
    check32("wrap_instr", instr_b, 32'h0010_0073);
    step();
    check1("wrap_next_req", req_b, 1'b1);
    check32("wrap_next_addr", addr_b, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall  in  1  hazard-unit hold; downstream IF/ID register does not accept this cycle.
REQ-005 redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  request address, word aligned.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid  in  1  read data valid, at least 1 cycle after grant.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 if_valid  out  1  if_instruction/if_pc_plus4 hold a real instruction.
REQ-013 if_pc  out  32  address of held instruction.
REQ-014 if_pc_plus4  out  32  if_pc + 4, modulo 2^32.
REQ-015 if_instruction  out  32  held instruction; NOP 32'h0000_0013 when if_valid=0.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD; one outstanding memory request max.
REQ-017 IDLE: imem_req=0; SHALL go to REQ next cycle.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_gnt SHALL go to WAIT; else stay REQ with imem_addr stable.
REQ-019 WAIT: imem_req=0; on imem_rvalid with discard=0 SHALL capture imem_rdata, if_pc=pc, if_pc_plus4=pc+4, if_valid=1, pc<=pc+4, go to HOLD.
REQ-020 HOLD: outputs stable while stall=1; when stall=0 instruction consumed that cycle, SHALL clear if_valid (instruction=NOP) and go to REQ next cycle.
REQ-021 Fetch latency: imem_gnt in the REQ cycle plus rvalid one cycle later yields if_valid=1 on the edge that samples rvalid (3 cycles REQ->HOLD minimum).
REQ-022 Redirect in IDLE or REQ without gnt: pc<=redirect_pc, state REQ; imem_addr changes next cycle.
REQ-023 Redirect in REQ with gnt same cycle: pc<=redirect_pc, go to WAIT with discard=1.
REQ-024 Redirect in WAIT, no rvalid: pc<=redirect_pc, discard=1, stay WAIT.
REQ-025 Redirect in WAIT with rvalid same cycle: response dropped, pc<=redirect_pc, go to REQ.
REQ-026 WAIT with discard=1 on rvalid: response dropped, discard cleared, go to REQ (fetches redirected pc).
REQ-027 Redirect in HOLD: if_valid cleared next cycle, pc<=redirect_pc, go to REQ; redirect wins over stall.
REQ-028 Redirect never produces if_valid=1 for a pre-redirect address after the redirect edge.
REQ-029 PC arithmetic 32-bit unsigned, wraps: pc 32'hFFFF_FFFC -> next 32'h0000_0000.
REQ-030 stall has no effect outside HOLD (fetch proceeds ahead, result held in HOLD).

Reset
REQ-031 On rst: pc=RESET_PC, state=IDLE, discard=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_pc_plus4=0, if_instruction=NOP.
REQ-032 Reset mid-request SHALL abandon it; a late imem_rvalid after reset release while not in WAIT SHALL be ignored.

Structure
REQ-033 Shared package SHALL hold state enum, NOP constant 32'h0000_0013, default RESET_PC.
REQ-034 One sub-module if_next_pc: combinational next-pc select (hold / pc+4 / redirect_pc aligned); FSM and output registers in top.

Verification
REQ-035 Reset release, gnt immediate, rvalid 1 cycle later, rdata 32'h00500093 -> imem_addr=0, if_valid=1, if_pc=0, if_pc_plus4=4, if_instruction=32'h00500093.
REQ-036 stall=1 for 3 cycles in HOLD -> outputs unchanged 3 cycles; stall=0 -> next request imem_addr=4.
REQ-037 Redirect to 32'h0000_0102 while in WAIT, then rvalid -> response dropped, if_valid stays 0, next imem_addr=32'h0000_0100.
REQ-038 Redirect and stall both 1 in HOLD -> if_valid=0 next cycle, imem_addr=redirect target.
REQ-039 RESET_PC=32'hFFFF_FFFC, one fetch -> if_pc_plus4=0, next imem_addr=0.
REQ-040 rst asserted in WAIT, rvalid arrives after release -> ignored, first fetch at RESET_PC.
